// File: rtl/sc_udp_tx_framer.sv
// sc_udp_tx_framer
// Turns one slow-control transmit request into a complete IPv4+UDP datagram.
// The datagram leaves as a byte stream: 20-byte IPv4 header, 8-byte UDP header
// with a zero UDP checksum, then the payload pulled from the client.
//
// Ports
//   clk, rstn          Ethernet clock; asynchronous active-low reset
//   tx_req / tx_ack    request level from the client, one-cycle grant pulse
//   tx_srcPort, tx_dstPort, tx_dstIP, tx_length
//                      request fields, latched on the grant cycle
//   tx_data, tx_start  payload byte and the client's first-byte marker
//   tx_datardy         the framer takes tx_data on this cycle
//   tx_done            client has finished; releases the handshake
//   eth_data/valid/sof/eof, eth_rdy
//                      registered output byte stream with ready backpressure
//   len_err, start_err one-cycle error pulses
//   ip_id              IPv4 identification counter
`timescale 1ns/1ps
module sc_udp_tx_framer #(
   parameter logic [31:0] SRC_IP      = 32'hC0A8_0102,
   parameter logic [7:0]  TTL         = 8'd64,
   parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        tx_req,
   output logic        tx_ack,
   input  logic [15:0] tx_srcPort,
   input  logic [15:0] tx_dstPort,
   input  logic [31:0] tx_dstIP,
   input  logic [15:0] tx_length,
   input  logic [7:0]  tx_data,
   input  logic        tx_start,
   output logic        tx_datardy,
   input  logic        tx_done,
   output logic [7:0]  eth_data,
   output logic        eth_valid,
   output logic        eth_sof,
   output logic        eth_eof,
   input  logic        eth_rdy,
   output logic        len_err,
   output logic        start_err,
   output logic [15:0] ip_id
);

   typedef enum logic [2:0] {IDLE, GRANT, CSUM, HDR, PAY, DRAIN, WAITDONE} state_t;

   state_t      state;
   logic [15:0] src_port;
   logic [15:0] dst_port;
   logic [31:0] dst_ip;
   logic [15:0] pay_len;
   logic [15:0] tot_len;
   logic [15:0] udp_len;
   logic [15:0] csum;
   logic [19:0] sum;
   logic [1:0]  csum_step;
   logic [4:0]  hdr_idx;
   logic [15:0] byte_cnt;
   logic        first_byte;
   logic        drained;

   logic        load;
   logic [19:0] hdr_sum;
   logic [223:0] hdr_vec;
   logic [223:0] hdr_shift;
   logic [7:0]  hdr_byte;

   // The output register can take a new byte when it is empty or being drained.
   assign load = !eth_valid || eth_rdy;

   // Payload is only pulled when the byte can go straight into the output register;
   // an oversized request is swallowed at full rate.
   assign tx_datardy = ((state == PAY) && load) || (state == DRAIN);

   // Raw 20-bit sum of the ten IPv4 header halfwords with the checksum field as zero.
   // Ten 16-bit terms cannot overflow 20 bits, so two folds always finish the job.
   assign hdr_sum = 20'h04500 + 20'h04000
                  + {4'h0, tot_len} + {4'h0, ip_id} + {4'h0, TTL, 8'h11}
                  + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                  + {4'h0, dst_ip[31:16]} + {4'h0, dst_ip[15:0]};

   // The whole 28-byte header as one big-endian vector; the current byte is the top
   // byte after shifting out the ones already sent.
   assign hdr_vec   = {16'h4500, tot_len, ip_id, 16'h4000, TTL, 8'h11, csum,
                       SRC_IP, dst_ip, src_port, dst_port, udp_len, 16'h0000};
   assign hdr_shift = hdr_vec << {hdr_idx, 3'b000};
   assign hdr_byte  = hdr_shift[223:216];

   // Main sequencer: grant, checksum, header, payload or drain, then wait for the
   // client to finish. A byte already accepted downstream clears the output register
   // unless the current state loads a replacement in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         tx_ack     <= 1'b0;
         len_err    <= 1'b0;
         start_err  <= 1'b0;
         eth_data   <= 8'h00;
         eth_valid  <= 1'b0;
         eth_sof    <= 1'b0;
         eth_eof    <= 1'b0;
         ip_id      <= 16'h0000;
         src_port   <= 16'h0000;
         dst_port   <= 16'h0000;
         dst_ip     <= 32'h0;
         pay_len    <= 16'h0000;
         tot_len    <= 16'h0000;
         udp_len    <= 16'h0000;
         csum       <= 16'h0000;
         sum        <= 20'h0;
         csum_step  <= 2'd0;
         hdr_idx    <= 5'd0;
         byte_cnt   <= 16'h0000;
         first_byte <= 1'b0;
         drained    <= 1'b0;
      end else begin
         tx_ack    <= 1'b0;
         len_err   <= 1'b0;
         start_err <= 1'b0;
         if (eth_valid && eth_rdy) begin
            eth_valid <= 1'b0;
            eth_sof   <= 1'b0;
            eth_eof   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (tx_req) begin
                  tx_ack <= 1'b1;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               src_port  <= tx_srcPort;
               dst_port  <= tx_dstPort;
               dst_ip    <= tx_dstIP;
               pay_len   <= tx_length;
               tot_len   <= tx_length + 16'd28;
               udp_len   <= tx_length + 16'd8;
               byte_cnt  <= tx_length;
               csum_step <= 2'd0;
               hdr_idx   <= 5'd0;
               if (tx_length > MAX_PAYLOAD) begin
                  len_err <= 1'b1;
                  drained <= 1'b1;
                  state   <= DRAIN;
               end else begin
                  drained <= 1'b0;
                  state   <= CSUM;
               end
            end
            CSUM: begin
               csum_step <= csum_step + 2'd1;
               case (csum_step)
                  2'd0:    sum <= hdr_sum;
                  2'd1:    sum <= {3'b000, {1'b0, sum[15:0]} + {13'h0, sum[19:16]}};
                  default: begin
                     csum  <= ~(sum[15:0] + {12'h000, sum[19:16]});
                     state <= HDR;
                  end
               endcase
            end
            HDR: begin
               if (load) begin
                  eth_data  <= hdr_byte;
                  eth_valid <= 1'b1;
                  eth_sof   <= (hdr_idx == 5'd0);
                  eth_eof   <= (hdr_idx == 5'd27) && (pay_len == 16'h0000);
                  if (hdr_idx == 5'd27) begin
                     byte_cnt   <= pay_len;
                     first_byte <= 1'b1;
                     state      <= (pay_len == 16'h0000) ? WAITDONE : PAY;
                  end else begin
                     hdr_idx <= hdr_idx + 5'd1;
                  end
               end
            end
            PAY: begin
               if (load) begin
                  eth_data   <= tx_data;
                  eth_valid  <= 1'b1;
                  eth_sof    <= 1'b0;
                  eth_eof    <= (byte_cnt == 16'd1);
                  byte_cnt   <= byte_cnt - 16'd1;
                  first_byte <= 1'b0;
                  if (first_byte && !tx_start) start_err <= 1'b1;
                  if (byte_cnt == 16'd1) state <= WAITDONE;
               end
            end
            DRAIN: begin
               byte_cnt <= byte_cnt - 16'd1;
               if (byte_cnt == 16'd1) state <= WAITDONE;
            end
            WAITDONE: begin
               // Only frames that actually went out consume an identification value.
               if (!eth_valid && tx_done) begin
                  if (!drained) ip_id <= ip_id + 16'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
